fetch_sequencer: RTL and testbench

- Multi-cycle instruction fetch stage directly upstream of the control decoder.
- Owns the PC and instruction register (IR), and runs the request/response handshake to instruction memory.
- Presents one instruction per EXEC cycle; the decoder consumes the opcode and returns ldpc, halt and stall.
- Applies PC redirect (JMP/JAL/JR/BEQZ/BNE) and the HALT stop.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/fetch_sequencer.sv | 83 ++++++++
 tb/tb_fetch_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, fetch-stage state encoding and
// instruction-field geometry used by the fetch sequencer and decoder.
package cpu_pkg;

  localparam int unsigned INSTR_W_DEF = 16;
  localparam int unsigned OPC_W       = 4;

  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_OR   = 4'b0011;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [OPC_W-1:0] OP_LD   = 4'b0101;
  localparam logic [OPC_W-1:0] OP_ST   = 4'b0110;
  localparam logic [OPC_W-1:0] OP_HALT = 4'b0111;
  localparam logic [OPC_W-1:0] OP_BEQZ = 4'b1000;
  localparam logic [OPC_W-1:0] OP_BNE  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'b1010;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'b1011;
  localparam logic [OPC_W-1:0] OP_JAL  = 4'b1100;
  localparam logic [OPC_W-1:0] OP_JR   = 4'b1101;
  localparam logic [OPC_W-1:0] OP_LI   = 4'b1110;
  localparam logic [OPC_W-1:0] OP_MUL  = 4'b1111;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_EXEC,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch stage: owns PC, IR and retired count, runs the imem
// request/response handshake and applies decoder redirect/halt/stall.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus1,
  input  logic               ldpc,
  input  logic [PC_W-1:0]    pc_target,
  input  logic               halt,
  input  logic               stall,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  fetch_state_e       state;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic [CNT_W-1:0]   retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      pc_q      <= PC_RST;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            ir_q  <= imem_rdata;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // stall outranks halt, halt outranks redirect
          if (!stall) begin
            if (halt) begin
              state <= ST_HALTED;
            end else begin
              pc_q      <= ldpc ? pc_target : pc_q + PC_W'(1);
              retired_q <= retired_q + CNT_W'(1);
              state     <= ST_FETCH;
            end
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_FETCH;
      endcase
    end
  end

  assign imem_req    = (state == ST_FETCH);
  assign instr_valid = (state == ST_EXEC);
  assign halted      = (state == ST_HALTED);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus1    = pc_q + PC_W'(1);
  assign instr       = ir_q;
  assign opcode      = ir_q[INSTR_W-1 -: OPC_W];
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios then random
// programs, checked against a transaction-level fetch/execute model.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic        instr_valid;
  logic [7:0]  pc;
  logic [7:0]  pc_plus1;
  logic        ldpc;
  logic [7:0]  pc_target;
  logic        halt;
  logic        stall;
  logic        halted;
  logic [15:0] retired;

  fetch_sequencer #(.PC_W(8), .INSTR_W(16), .RESET_PC(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .pc(pc), .pc_plus1(pc_plus1),
    .ldpc(ldpc), .pc_target(pc_target), .halt(halt), .stall(stall),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Instruction memory contents and architectural model
  logic [15:0] mem [256];
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_ret;
  bit          m_halted;

  int unsigned passed = 0;
  int unsigned total  = 0;

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [7:0] tgt);
    return {op, 4'h0, tgt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset(input bit rv_same);
    rst = 1'b1; imem_ready = 1'b0; ldpc = 1'b0; halt = 1'b0; stall = 1'b0;
    imem_rvalid = rv_same; imem_rdata = 16'hBEEF;
    @(negedge clk);
    rst = 1'b0; imem_rvalid = 1'b0;
    m_pc = 8'h00; m_ir = 16'h0000; m_ret = 16'h0000; m_halted = 1'b0;
    chk("rst_req", imem_req, 1);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ivalid", instr_valid, 0);
  endtask

  // One full instruction: fetch with rdy wait cycles, rvalid after rv WAIT
  // cycles, st stall cycles in EXEC; the bench plays the decoder.
  task automatic do_instr(input int rdy, input int rv, input int st, input bit force_ldpc);
    int          c0;
    logic [15:0] w;
    logic [3:0]  op;
    logic [7:0]  nxt;
    bit          do_ld, do_halt;
    c0 = cyc;
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc);
    for (int i = 0; i < rdy; i++) begin
      imem_ready = 1'b0; imem_rvalid = 1'($urandom_range(0, 1)); imem_rdata = 16'($urandom);
      @(negedge clk);
      chk("bp_req", imem_req, 1);
      chk("bp_instr", instr, m_ir);
    end
    imem_ready = 1'b1; imem_rvalid = 1'b0;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("wait_req", imem_req, 0);
    for (int i = 0; i < rv; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("wait_ir_hold", instr, m_ir);
      chk("wait_ivalid", instr_valid, 0);
    end
    w = mem[m_pc];
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = w;
    @(negedge clk);
    imem_rvalid = 1'b0; imem_rdata = 16'($urandom);
    m_ir = w;
    op   = w[15:12];
    nxt  = m_pc + 8'd1;
    chk("exec_ivalid", instr_valid, 1);
    chk("exec_instr", instr, w);
    chk("exec_opcode", opcode, op);
    chk("exec_pc", pc, m_pc);
    chk("exec_pc_plus1", pc_plus1, nxt);
    chk("exec_retired", retired, m_ret);
    do_ld   = (op == OP_JMP) || force_ldpc;
    do_halt = (op == OP_HALT);
    ldpc = do_ld; halt = do_halt; pc_target = w[7:0];
    for (int i = 0; i < st; i++) begin
      stall = 1'b1;
      @(negedge clk);
      chk("stall_ivalid", instr_valid, 1);
      chk("stall_pc", pc, m_pc);
      chk("stall_retired", retired, m_ret);
    end
    stall = 1'b0;
    @(negedge clk);
    ldpc = 1'b0; halt = 1'b0; pc_target = 8'($urandom);
    if (do_halt) begin
      m_halted = 1'b1;
    end else begin
      m_pc  = do_ld ? w[7:0] : nxt;
      m_ret = m_ret + 16'd1;
    end
    chk("post_halted", halted, m_halted);
    chk("post_req", imem_req, !m_halted);
    chk("post_ivalid", instr_valid, 0);
    chk("post_pc", pc, m_pc);
    chk("post_retired", retired, m_ret);
    chk("period", cyc - c0, 3 + rdy + rv + st);
  endtask

  task automatic halted_idle(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ready = 1'($urandom_range(0, 1)); imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata = 16'($urandom); ldpc = 1'($urandom_range(0, 1));
      halt = 1'($urandom_range(0, 1)); stall = 1'($urandom_range(0, 1));
      pc_target = 8'($urandom);
      @(negedge clk);
      chk("hlt_halted", halted, 1);
      chk("hlt_req", imem_req, 0);
      chk("hlt_pc", pc, m_pc);
      chk("hlt_retired", retired, m_ret);
    end
    imem_ready = 1'b0; imem_rvalid = 1'b0; ldpc = 1'b0; halt = 1'b0; stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    ldpc = 1'b0; pc_target = '0; halt = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);
    do_reset(1'b0);

    // Sequential fetch: ADD x3 then HALT
    for (int i = 0; i < 256; i++) mem[i] = mk(OP_ADD, 8'(i));
    mem[3] = mk(OP_HALT, 8'h00);
    for (int k = 0; k < 4; k++) do_instr(0, 0, 0, 1'b0);
    chk("seq_retired", retired, 3);
    chk("seq_halted", halted, 1);
    halted_idle(5);
    do_reset(1'b0);

    // Redirect, backpressure, stall, wrap
    mem[0]    = mk(OP_JMP, 8'h05);
    mem[5]    = mk(OP_JMP, 8'h20);
    mem[8'h20] = mk(OP_ADD, 8'h11);
    mem[8'h21] = mk(OP_SUB, 8'h22);
    mem[8'h22] = mk(OP_JMP, 8'hFF);
    mem[8'hFF] = mk(OP_MUL, 8'h33);
    do_instr(0, 0, 0, 1'b0);
    do_instr(0, 0, 0, 1'b0);
    chk("redir_addr", imem_addr, 8'h20);
    chk("redir_retired", retired, 2);
    do_instr(2, 2, 0, 1'b0);
    do_instr(0, 0, 4, 1'b0);
    do_instr(0, 0, 0, 1'b0);
    do_instr(1, 0, 1, 1'b0);
    chk("wrap_addr", imem_addr, 8'h00);

    // Reset while in WAIT with rvalid arriving on the same edge
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("mid_wait_req", imem_req, 0);
    do_reset(1'b1);

    // halt and ldpc together: halt wins, pc not loaded
    mem[0] = mk(OP_HALT, 8'h33);
    do_instr(0, 0, 1, 1'b1);
    chk("hl_pc", pc, 8'h00);
    halted_idle(3);
    do_reset(1'b0);

    // Random programs
    for (int i = 0; i < 256; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0)     mem[i] = mk(OP_HALT, 8'($urandom));
      else if (r < 5) mem[i] = mk(OP_JMP, 8'($urandom));
      else            mem[i] = mk(4'($urandom_range(0, 6)), 8'($urandom));
    end
    for (int n = 0; n < 60; n++) begin
      if (m_halted) begin
        halted_idle(2);
        do_reset(1'b0);
      end
      do_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
